// File: rtl/gps_sample_packer.sv
// GPS I/Q sample packer: captures 2-bit I (and optionally 2-bit Q) samples on
// each DATAREADY strobe, packs them MSB-first into bytes and queues the bytes
// in a first-word-fall-through FIFO toward the SPI serializer. Bytes that
// arrive while the FIFO is full are dropped and counted.
module gps_sample_packer #(
    parameter int FIFO_AW = 4,
    parameter bit IQ_MODE = 1'b1
) (
    input  logic               MCU_CLK_25_000,
    input  logic               RESET_P,
    input  logic               GPS_I0,
    input  logic               GPS_I1,
    input  logic               GPS_Q0,
    input  logic               GPS_Q1,
    input  logic               DATAREADY,
    output logic [7:0]         BYTE_DATA,
    output logic               BYTE_VALID,
    input  logic               BYTE_READY,
    output logic [FIFO_AW:0]   FIFO_LEVEL,
    output logic               OVERFLOW,
    input  logic               CLR_OVF,
    output logic [15:0]        DROP_COUNT
);

    localparam int              NW        = IQ_MODE ? 4 : 2;
    localparam int              DEPTH     = 1 << FIFO_AW;
    localparam logic [1:0]      LAST_SLOT = IQ_MODE ? 2'd1 : 2'd3;
    localparam logic [FIFO_AW:0]   LVL_FULL = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   LVL_ONE  = 1;
    localparam logic [FIFO_AW-1:0] PTR_ONE  = 1;

    // Packing state
    logic [1:0]         slot_q, slot_d;
    logic [7:0]         shift_q, shift_d;
    logic [NW-1:0]      sample_w;
    logic [7:0]         packed_w;
    logic               push_w;

    // FIFO state
    logic [7:0]         mem_q [0:DEPTH-1];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic               valid_q;
    logic               pop_w, full_w, accept_w, drop_w;

    // Overflow reporting
    logic               ovf_q, ovf_d;
    logic [15:0]        drop_q, drop_d;

    if (IQ_MODE) begin : g_iq
        assign sample_w = {GPS_I1, GPS_I0, GPS_Q1, GPS_Q0};
    end else begin : g_i_only
        assign sample_w = {GPS_I1, GPS_I0};
    end

    // Earlier samples already sit in the low bits of shift_q; shifting left
    // and appending the current sample keeps the first sample in the MSBs.
    assign packed_w = {shift_q[7-NW:0], sample_w};
    assign push_w   = DATAREADY && (slot_q == LAST_SLOT);

    assign pop_w    = BYTE_READY && valid_q;
    assign full_w   = (level_q == LVL_FULL);
    // A pop in the same cycle frees the slot the push needs, so full+pop never drops.
    assign accept_w = push_w && (!full_w || pop_w);
    assign drop_w   = push_w && full_w && !pop_w;

    // Next-state logic for packer, FIFO pointers/level and overflow reporting
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        slot_d   = slot_q;
        shift_d  = shift_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;

        if (DATAREADY) begin
            if (slot_q == LAST_SLOT) begin
                slot_d  = 2'd0;
                shift_d = 8'h00;
            end else begin
                slot_d  = slot_q + 2'd1;
                shift_d = packed_w;
            end
        end

        if (accept_w) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_w)    rd_ptr_d = rd_ptr_q + PTR_ONE;

        case ({accept_w, pop_w})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        // A drop coinciding with a clear wins and restarts the count at one.
        if (drop_w) begin
            ovf_d = 1'b1;
            if (CLR_OVF)                drop_d = 16'd1;
            else if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        end else if (CLR_OVF) begin
            ovf_d  = 1'b0;
            drop_d = 16'd0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge MCU_CLK_25_000) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (RESET_P) begin
            slot_q   <= 2'd0;
            shift_q  <= 8'h00;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            drop_q   <= 16'd0;
        end else begin
            slot_q   <= slot_d;
            shift_q  <= shift_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= (level_d != '0);
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    // FIFO storage write
    always_ff @(posedge MCU_CLK_25_000) begin
        // NOTE: storage has no reset; entries are only observable once the level covers them.
        if (!RESET_P && accept_w) mem_q[wr_ptr_q] <= packed_w;
    end

    assign BYTE_DATA  = valid_q ? mem_q[rd_ptr_q] : 8'h00;
    assign BYTE_VALID = valid_q;
    assign FIFO_LEVEL = level_q;
    assign OVERFLOW   = ovf_q;
    assign DROP_COUNT = drop_q;

endmodule
